lcd_ctrl: RTL and testbench



---
 rtl/lcd_ctrl_pkg.sv | 85 ++++++++
 rtl/lcd_bus_txn.sv | 112 +++++++++++
 rtl/lcd_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared codes, state encodings and select tables for the LCD control FSM
// and its bus-transaction sequencer.
package lcd_ctrl_pkg;

    localparam logic [1:0] SEL_CLEAR   = 2'd0;
    localparam logic [1:0] SEL_DISPON  = 2'd1;
    localparam logic [1:0] SEL_ENTRY   = 2'd2;
    localparam logic [1:0] SEL_FUNCSET = 2'd3;

    localparam logic [1:0] SRC_DIGIT = 2'd0;
    localparam logic [1:0] SRC_OP    = 2'd1;
    localparam logic [1:0] SRC_BLANK = 2'd2;

    localparam logic [3:0] INIT_LAST  = 4'd3;
    localparam logic [3:0] FRAME_LAST = 4'd9;

    typedef enum logic [1:0] {
        ST_POWERUP = 2'd0,
        ST_INIT    = 2'd1,
        ST_IDLE    = 2'd2,
        ST_FRAME   = 2'd3
    } ctrl_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_SETUP = 3'd1,
        TX_EHI   = 3'd2,
        TX_HOLD  = 3'd3,
        TX_WAIT  = 3'd4
    } txn_state_t;

    typedef struct packed {
        logic [1:0] init_sel;
        logic       data_sel;
        logic [1:0] src;
        logic [1:0] index;
    } sel_t;

    function automatic sel_t init_step_sel(input logic [3:0] step);
        sel_t s;
        s.init_sel = SEL_CLEAR;
        s.data_sel = 1'b0;
        s.src      = SRC_BLANK;
        s.index    = 2'd0;
        case (step)
            4'd0:    s.init_sel = SEL_FUNCSET;
            4'd1:    s.init_sel = SEL_DISPON;
            4'd2:    s.init_sel = SEL_ENTRY;
            default: s.init_sel = SEL_CLEAR;
        endcase
        return s;
    endfunction

    // Frame order: clear, four digits, one blank, four mnemonic characters.
    function automatic sel_t frame_step_sel(input logic [3:0] step);
        sel_t s;
        s.init_sel = SEL_CLEAR;
        s.data_sel = 1'b0;
        s.src      = SRC_BLANK;
        s.index    = 2'd0;
        case (step)
            4'd1, 4'd2, 4'd3, 4'd4: begin
                s.data_sel = 1'b1;
                s.src      = SRC_DIGIT;
                s.index    = step[1:0] - 2'd1;
            end
            4'd5: begin
                s.data_sel = 1'b1;
                s.src      = SRC_BLANK;
            end
            4'd6, 4'd7, 4'd8, 4'd9: begin
                s.data_sel = 1'b1;
                s.src      = SRC_OP;
                s.index    = step[1:0] - 2'd2;
            end
            default: s.data_sel = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic is_clear_cmd(input sel_t s);
        return (s.data_sel == 1'b0) && (s.init_sel == SEL_CLEAR);
    endfunction

endpackage

// File: rtl/lcd_bus_txn.sv
// One HD44780 write cycle: SETUP (bus valid), EHI (E high), HOLD (E low, bus
// still driven), WAIT (execution time), then a one-cycle done pulse.
module lcd_bus_txn import lcd_ctrl_pkg::*; #(
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int CNT_W          = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_clear,
    output logic lcd_e,
    output logic db_sel,
    output logic done
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHI_LD   = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLEAR_WAIT_CYC - 1);

    txn_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             clear_r, clear_nxt_s;
    logic             lcd_e_r, lcd_e_nxt_s;
    logic             db_sel_r, db_sel_nxt_s;
    logic             done_r, done_nxt_s;

    // Next-state and next-output decode; outputs describe the state being entered.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        clear_nxt_s  = clear_r;
        lcd_e_nxt_s  = 1'b0;
        db_sel_nxt_s = 1'b0;
        done_nxt_s   = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (start) begin
                    state_nxt_s  = TX_SETUP;
                    cnt_nxt_s    = SETUP_LD;
                    clear_nxt_s  = is_clear;
                    db_sel_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = TX_IDLE;
                end
            end
            TX_SETUP: begin
                db_sel_nxt_s = 1'b1;
                if (cnt_r == '0) begin
                    state_nxt_s = TX_EHI;
                    cnt_nxt_s   = EHI_LD;
                    lcd_e_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            TX_EHI: begin
                db_sel_nxt_s = 1'b1;
                if (cnt_r == '0) begin
                    state_nxt_s = TX_HOLD;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                    lcd_e_nxt_s = 1'b1;
                end
            end
            TX_HOLD: begin
                state_nxt_s = TX_WAIT;
                if (clear_r) begin
                    cnt_nxt_s = CLR_LD;
                end else begin
                    cnt_nxt_s = CMD_LD;
                end
            end
            TX_WAIT: begin
                if (cnt_r == '0) begin
                    state_nxt_s = TX_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: state_nxt_s = TX_IDLE;
        endcase
    end

    // State, counter and registered strobes; reset drops lcd_e immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= TX_IDLE;
            cnt_r    <= '0;
            clear_r  <= 1'b0;
            lcd_e_r  <= 1'b0;
            db_sel_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            clear_r  <= clear_nxt_s;
            lcd_e_r  <= lcd_e_nxt_s;
            db_sel_r <= db_sel_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign lcd_e  = lcd_e_r;
    assign db_sel = db_sel_r;
    assign done   = done_r;

endmodule

// File: rtl/lcd_ctrl.sv
// LCD control FSM: power-up wait, init command sequence, periodic refresh frames.
// Build option LCD_BLINK_EN enables the free-running blink phase generator.
module lcd_ctrl import lcd_ctrl_pkg::*; #(
    parameter int POWERUP_CYC    = 750000,
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int REFRESH_CYC    = 2500000,
`ifdef LCD_BLINK_EN
    parameter int BLINK_CYC      = 12500000,
`endif
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh_req,
    output logic [1:0] init_sel,
    output logic       data_sel,
    output logic       db_sel,
    output logic [1:0] state,
    output logic [1:0] index,
    output logic       blink,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       busy,
    output logic       init_done
);

    localparam logic [CNT_W-1:0] POWERUP_LD = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] REFRESH_LD = CNT_W'(REFRESH_CYC - 1);

    ctrl_state_t      state_r, state_nxt_s;
    logic [CNT_W-1:0] timer_r, timer_nxt_s;
    logic [3:0]       step_r, step_nxt_s;
    logic             pending_r, pending_nxt_s;
    logic             start_r, start_nxt_s;
    logic             clear_r, clear_nxt_s;
    logic             init_done_r, init_done_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             lcd_rs_r;
    sel_t             sel_r, sel_nxt_s;
    logic             txn_done_s;

    // Sequencing of power-up, init commands, idle refresh timing and frames.
    always_comb begin
        state_nxt_s     = state_r;
        step_nxt_s      = step_r;
        start_nxt_s     = 1'b0;
        init_done_nxt_s = init_done_r;
        pending_nxt_s   = pending_r | refresh_req;
        sel_nxt_s       = sel_r;
        if (timer_r == '0) begin
            timer_nxt_s = '0;
        end else begin
            timer_nxt_s = timer_r - CNT_W'(1);
        end
        case (state_r)
            ST_POWERUP: begin
                if (timer_r == '0) begin
                    state_nxt_s = ST_INIT;
                    step_nxt_s  = 4'd0;
                    sel_nxt_s   = init_step_sel(4'd0);
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_POWERUP;
                end
            end
            ST_INIT: begin
                if (txn_done_s && (step_r == INIT_LAST)) begin
                    state_nxt_s     = ST_IDLE;
                    init_done_nxt_s = 1'b1;
                end else if (txn_done_s) begin
                    step_nxt_s  = step_r + 4'd1;
                    sel_nxt_s   = init_step_sel(step_r + 4'd1);
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            // The timer is already expired after power-up, so the first frame follows init.
            ST_IDLE: begin
                if ((timer_r == '0) || pending_r || refresh_req) begin
                    state_nxt_s   = ST_FRAME;
                    timer_nxt_s   = REFRESH_LD;
                    pending_nxt_s = 1'b0;
                    step_nxt_s    = 4'd0;
                    sel_nxt_s     = frame_step_sel(4'd0);
                    start_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (txn_done_s && (step_r == FRAME_LAST)) begin
                    state_nxt_s = ST_IDLE;
                end else if (txn_done_s) begin
                    step_nxt_s  = step_r + 4'd1;
                    sel_nxt_s   = frame_step_sel(step_r + 4'd1);
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_FRAME;
                end
            end
            default: state_nxt_s = ST_POWERUP;
        endcase
        if (start_nxt_s) begin
            clear_nxt_s = is_clear_cmd(sel_nxt_s);
        end else begin
            clear_nxt_s = clear_r;
        end
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Controller registers; selects move only together with a new start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_POWERUP;
            timer_r        <= POWERUP_LD;
            step_r         <= 4'd0;
            pending_r      <= 1'b0;
            start_r        <= 1'b0;
            clear_r        <= 1'b0;
            init_done_r    <= 1'b0;
            busy_r         <= 1'b1;
            lcd_rs_r       <= 1'b0;
            sel_r.init_sel <= SEL_FUNCSET;
            sel_r.data_sel <= 1'b0;
            sel_r.src      <= SRC_BLANK;
            sel_r.index    <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            step_r      <= step_nxt_s;
            pending_r   <= pending_nxt_s;
            start_r     <= start_nxt_s;
            clear_r     <= clear_nxt_s;
            init_done_r <= init_done_nxt_s;
            busy_r      <= busy_nxt_s;
            lcd_rs_r    <= sel_nxt_s.data_sel;
            sel_r       <= sel_nxt_s;
        end
    end

    lcd_bus_txn #(
        .SETUP_CYC      (SETUP_CYC),
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
        .CNT_W          (CNT_W)
    ) u_txn (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_r),
        .is_clear (clear_r),
        .lcd_e    (lcd_e),
        .db_sel   (db_sel),
        .done     (txn_done_s)
    );

`ifdef LCD_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LD = CNT_W'(BLINK_CYC - 1);
    logic [CNT_W-1:0] blink_cnt_r;
    logic             blink_r;

    // Free-running blink phase, independent of the controller state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (blink_cnt_r == BLINK_LD) begin
            blink_cnt_r <= '0;
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + CNT_W'(1);
        end
    end

    assign blink = blink_r;
`else
    assign blink = 1'b0;
`endif

    assign init_sel  = sel_r.init_sel;
    assign data_sel  = sel_r.data_sel;
    assign state     = sel_r.src;
    assign index     = sel_r.index;
    assign lcd_rs    = lcd_rs_r;
    assign lcd_rw    = 1'b0;
    assign busy      = busy_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: records every E pulse on the bus and compares it with the
// expected init/frame transaction lists, timing rules and refresh behaviour.
module tb_lcd_ctrl;

    localparam int POWERUP = 20;
    localparam int SETUP   = 2;
    localparam int EPULSE  = 3;
    localparam int CMDW    = 5;
    localparam int CLRW    = 10;
    localparam int REFRESH = 300;
    localparam int BLINKC  = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       refresh_req;
    logic [1:0] init_sel;
    logic       data_sel;
    logic       db_sel;
    logic [1:0] state;
    logic [1:0] index;
    logic       blink;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       busy;
    logic       init_done;

    always #5 clk = ~clk;

    lcd_ctrl #(
`ifdef LCD_BLINK_EN
        .BLINK_CYC      (BLINKC),
`endif
        .POWERUP_CYC    (POWERUP),
        .SETUP_CYC      (SETUP),
        .E_PULSE_CYC    (EPULSE),
        .CMD_WAIT_CYC   (CMDW),
        .CLEAR_WAIT_CYC (CLRW),
        .REFRESH_CYC    (REFRESH),
        .CNT_W          (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .refresh_req (refresh_req),
        .init_sel    (init_sel),
        .data_sel    (data_sel),
        .db_sel      (db_sel),
        .state       (state),
        .index       (index),
        .blink       (blink),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .busy        (busy),
        .init_done   (init_done)
    );

    typedef struct {
        int         cyc;
        logic [1:0] isel;
        logic       ds;
        logic [1:0] src;
        logic [1:0] idx;
        logic       rs;
        logic       idone;
        int         setup;
        int         gap;
    } pulse_t;

    typedef struct {
        logic       ds;
        logic [1:0] isel;
        logic [1:0] src;
        logic [1:0] idx;
    } txn_t;

    pulse_t pq[$];
    pulse_t p_tmp;
    txn_t   fexp[$];
    int     width_q[$];
    int     blink_iv[$];
    int     exp_init[4] = '{3, 1, 2, 0};

    int   cyc = 0, errors = 0, checks = 0, sel_changes = 0, blink_high = 0;
    int   db_hi = 0, db_lo = 0, e_len = 0, cur_gap = 0, blink_last = 0, idone_cyc = 0;
    logic e_prev = 1'b0, db_prev = 1'b0, blink_prev = 1'b0, idone_prev = 1'b0;
    logic [6:0] sel_prev = 7'd0;

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            e_prev     = 1'b0;
            db_prev    = 1'b0;
            db_hi      = 0;
            db_lo      = 0;
            e_len      = 0;
            idone_prev = 1'b0;
            blink_prev = 1'b0;
            blink_last = cyc;
            blink_iv.delete();
        end else begin
            if (db_sel && db_prev && ({init_sel, data_sel, state, index} != sel_prev))
                sel_changes = sel_changes + 1;
            if (db_sel) begin
                if (!db_prev) cur_gap = db_lo;
                db_hi = db_hi + 1;
                db_lo = 0;
            end else begin
                db_lo = db_lo + 1;
                db_hi = 0;
            end
            if (lcd_e && !e_prev) begin
                p_tmp.cyc   = cyc;
                p_tmp.isel  = init_sel;
                p_tmp.ds    = data_sel;
                p_tmp.src   = state;
                p_tmp.idx   = index;
                p_tmp.rs    = lcd_rs;
                p_tmp.idone = init_done;
                p_tmp.setup = db_hi - 1;
                p_tmp.gap   = cur_gap;
                pq.push_back(p_tmp);
                e_len = 1;
            end else if (lcd_e) begin
                e_len = e_len + 1;
            end else if (e_prev) begin
                width_q.push_back(e_len);
            end
            if (init_done && !idone_prev) idone_cyc = cyc;
            if (blink !== blink_prev) begin
                blink_iv.push_back(cyc - blink_last);
                blink_last = cyc;
            end
            if (blink !== 1'b0) blink_high = blink_high + 1;
            e_prev     = lcd_e;
            db_prev    = db_sel;
            idone_prev = init_done;
            blink_prev = blink;
        end
        sel_prev = {init_sel, data_sel, state, index};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((pq.size() < n) && (k < budget)) begin
            @(posedge clk);
            k = k + 1;
        end
        chk(tag, 32'(pq.size() >= n), 32'd1);
    endtask

    task automatic pulse_req();
        @(posedge clk);
        #1 refresh_req = 1'b1;
        @(posedge clk);
        #1 refresh_req = 1'b0;
    endtask

    // Expected frame contents, written straight from the display layout.
    task automatic build_frame_model();
        txn_t t;
        fexp.delete();
        t.ds = 1'b0; t.isel = 2'd0; t.src = 2'd2; t.idx = 2'd0;
        fexp.push_back(t);
        for (int i = 0; i < 4; i++) begin
            t.ds = 1'b1; t.src = 2'd0; t.idx = 2'(i);
            fexp.push_back(t);
        end
        t.ds = 1'b1; t.src = 2'd2; t.idx = 2'd0;
        fexp.push_back(t);
        for (int i = 0; i < 4; i++) begin
            t.ds = 1'b1; t.src = 2'd1; t.idx = 2'(i);
            fexp.push_back(t);
        end
    endtask

    task automatic check_frame(input int base, input string tag);
        int need_wait;
        chk({tag, "_present"}, 32'(width_q.size() >= base + 10), 32'd1);
        if (width_q.size() < base + 10) return;
        for (int k = 0; k < 10; k++) begin
            chk({tag, "_data_sel"}, 32'(pq[base+k].ds), 32'(fexp[k].ds));
            if (fexp[k].ds) begin
                chk({tag, "_state"}, 32'(pq[base+k].src), 32'(fexp[k].src));
                chk({tag, "_index"}, 32'(pq[base+k].idx), 32'(fexp[k].idx));
            end else begin
                chk({tag, "_init_sel"}, 32'(pq[base+k].isel), 32'(fexp[k].isel));
            end
            chk({tag, "_rs"}, 32'(pq[base+k].rs), 32'(fexp[k].ds));
            chk({tag, "_setup"}, 32'(pq[base+k].setup), 32'(SETUP));
            chk({tag, "_width"}, 32'(width_q[base+k]), 32'(EPULSE));
            if (k > 0) begin
                need_wait = fexp[k-1].ds ? CMDW : CLRW;
                chk({tag, "_gap"}, 32'(pq[base+k].gap >= need_wait), 32'd1);
            end
        end
    endtask

    task automatic check_init(input int rel, input string tag);
        chk({tag, "_powerup"}, 32'(pq[0].cyc - rel >= POWERUP), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_init_sel"}, 32'(pq[i].isel), 32'(exp_init[i]));
            chk({tag, "_data_sel"}, 32'(pq[i].ds), 32'd0);
            chk({tag, "_rs"}, 32'(pq[i].rs), 32'd0);
            chk({tag, "_done_early"}, 32'(pq[i].idone), 32'd0);
            chk({tag, "_width"}, 32'(width_q[i]), 32'(EPULSE));
            if (i > 0) chk({tag, "_gap"}, 32'(pq[i].gap >= CMDW), 32'd1);
        end
    endtask

    int rel, k, t_wait;

    initial begin
        rst_n       = 1'b0;
        refresh_req = 1'b0;
        build_frame_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcd_e", 32'(lcd_e), 32'd0);
        chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        chk("rst_db_sel", 32'(db_sel), 32'd0);
        chk("rst_data_sel", 32'(data_sel), 32'd0);
        chk("rst_init_sel", 32'(init_sel), 32'd3);
        chk("rst_state", 32'(state), 32'd2);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_init_done", 32'(init_done), 32'd0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        rel = cyc;
        wait_pulses(4, 400, "init_pulses");
        repeat (6) @(posedge clk);
        check_init(rel, "init");
        k = 0;
        while ((init_done !== 1'b1) && (k < 100)) begin
            @(posedge clk);
            k = k + 1;
        end
        chk("init_done_set", 32'(init_done), 32'd1);
        chk("init_done_after_clear_wait", 32'(idone_cyc - (pq[3].cyc + EPULSE) > CLRW), 32'd1);

        // Frame right after init, with three collapsed requests during it.
        wait_pulses(5, 300, "frame1_start");
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(3, 25)) @(posedge clk);
            pulse_req();
        end
        wait_pulses(24, 800, "frame2_pulses");
        repeat (6) @(posedge clk);
        check_frame(4, "frame1");
        check_frame(14, "frame2");
        chk("extra_frame_early", 32'(pq[14].cyc - pq[4].cyc < REFRESH), 32'd1);
        chk("extra_frame_immediate", 32'(pq[14].gap <= CMDW + 6), 32'd1);

        wait_pulses(34, 800, "frame3_pulses");
        repeat (6) @(posedge clk);
        check_frame(24, "frame3");
        chk("refresh_period", 32'(pq[24].cyc - pq[14].cyc), 32'(REFRESH));

        // Request from IDLE.
        k = 0;
        while ((busy !== 1'b0) && (k < 300)) begin
            @(posedge clk);
            k = k + 1;
        end
        repeat ($urandom_range(5, 80)) @(posedge clk);
        #1 chk("idle_busy_low", 32'(busy), 32'd0);
        t_wait = pq.size();
        pulse_req();
        @(negedge clk);
        chk("idle_req_busy", 32'(busy), 32'd1);
        wait_pulses(t_wait + 1, 20, "idle_req_frame_start");
        wait_pulses(45, 800, "frame5_start");
        repeat (6) @(posedge clk);
        check_frame(34, "frame4");
        chk("reload_on_request", 32'(pq[44].cyc - pq[34].cyc), 32'(REFRESH));

        // Reset in the middle of an E pulse.
        k = 0;
        do begin
            @(negedge clk);
            k = k + 1;
        end while ((lcd_e !== 1'b1) && (k < 200));
        chk("found_ehi", 32'(lcd_e), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_lcd_e", 32'(lcd_e), 32'd0);
        chk("async_rst_db_sel", 32'(db_sel), 32'd0);
        chk("async_rst_init_done", 32'(init_done), 32'd0);
        pq.delete();
        width_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rel = cyc;
        wait_pulses(4, 400, "reinit_pulses");
        repeat (6) @(posedge clk);
        check_init(rel, "reinit");
        repeat (60) @(posedge clk);

`ifdef LCD_BLINK_EN
        chk("blink_toggles", 32'(blink_iv.size() >= 3), 32'd1);
        for (int i = 1; i < blink_iv.size(); i++)
            chk("blink_interval", 32'(blink_iv[i]), 32'(BLINKC));
`else
        chk("blink_const_zero", 32'(blink_high), 32'd0);
`endif
        chk("selects_stable", 32'(sel_changes), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
